// File: rtl/uart_fifo_sched.sv
// uart_fifo_sched: owns both ports of the UART byte FIFO.
// Write side arbitrates 3-byte mouse packets against single command bytes,
// admitting a source only when its whole payload fits. Read side drains one
// byte at a time into the UART transmitter under a start/done handshake.
module uart_fifo_sched #(
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pkt_valid,
  input  logic [23:0]   pkt_data,
  output logic          pkt_ready,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          fifo_write,
  output logic [7:0]    fifo_data_in,
  input  logic          fifo_full,
  output logic          fifo_read,
  input  logic [7:0]    fifo_data_out,
  input  logic          fifo_empty,
  input  logic          tx_enable,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic [LW-1:0] level,
  output logic          err
);

  typedef enum logic [2:0] {W_IDLE, W_B0, W_B1, W_B2, W_BYTE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_START, R_WAIT} r_state_e;

  // Highest pre-grant level at which each source's payload still fits.
  localparam logic [LW-1:0] PKT_MAX  = LW'(DEPTH - 3);
  localparam logic [LW-1:0] BYTE_MAX = LW'(DEPTH - 1);

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic          last_pkt_q, last_pkt_d;   // 1: packet source won the last grant
  logic [23:0]   wdata_q, wdata_d;         // latched packet, or byte in [7:0]
  logic [7:0]    tx_data_q, tx_data_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic          pkt_elig, byte_elig;

  // Write FSM: arbitration in idle, then replay the latched payload.
  always_comb begin
    w_state_d    = w_state_q;
    last_pkt_d   = last_pkt_q;
    wdata_d      = wdata_q;
    pkt_ready    = 1'b0;
    byte_ready   = 1'b0;
    fifo_write   = 1'b0;
    fifo_data_in = 8'h00;
    // Readies are forced low while reset is held so every output reads 0.
    pkt_elig     = reset && pkt_valid  && (level_q <= PKT_MAX);
    byte_elig    = reset && byte_valid && (level_q <= BYTE_MAX);
    case (w_state_q)
      W_IDLE: begin
        // On a tie the packet wins unless it won last time.
        if (pkt_elig && (!byte_elig || !last_pkt_q)) begin
          pkt_ready  = 1'b1;
          wdata_d    = pkt_data;
          last_pkt_d = 1'b1;
          w_state_d  = W_B0;
        end else if (byte_elig) begin
          byte_ready = 1'b1;
          wdata_d    = {16'h0000, byte_data};
          last_pkt_d = 1'b0;
          w_state_d  = W_BYTE;
        end
      end
      W_B0: begin
        fifo_write   = 1'b1;
        fifo_data_in = wdata_q[7:0];
        w_state_d    = W_B1;
      end
      W_B1: begin
        fifo_write   = 1'b1;
        fifo_data_in = wdata_q[15:8];
        w_state_d    = W_B2;
      end
      W_B2: begin
        fifo_write   = 1'b1;
        fifo_data_in = wdata_q[23:16];
        w_state_d    = W_IDLE;
      end
      W_BYTE: begin
        fifo_write   = 1'b1;
        fifo_data_in = wdata_q[7:0];
        w_state_d    = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: pop, capture the FIFO output a cycle later, pulse start, wait done.
  always_comb begin
    r_state_d = r_state_q;
    tx_data_d = tx_data_q;
    fifo_read = 1'b0;
    tx_start  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if ((level_q != '0) && tx_enable) begin
          fifo_read = 1'b1;
          r_state_d = R_LOAD;
        end
      end
      R_LOAD: begin
        tx_data_d = fifo_data_out;
        r_state_d = R_START;
      end
      R_START: begin
        tx_start  = 1'b1;
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (tx_done) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Occupancy tracking and sticky protocol-error flag.
  always_comb begin
    level_d = level_q;
    case ({fifo_write, fifo_read})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    err_d = err_q | (fifo_write & fifo_full) | (fifo_read & fifo_empty);
  end

  // State registers; last grant resets to the byte source so packets win first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      last_pkt_q <= 1'b0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      last_pkt_q <= last_pkt_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

  assign tx_data = tx_data_q;
  assign level   = level_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Bench for uart_fifo_sched: behavioural FIFO and transmitter around the DUT,
// expected write/transmit byte streams kept in scoreboard queues.
module tb_uart_fifo_sched;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          pkt_valid, pkt_ready;
  logic [23:0]   pkt_data;
  logic          byte_valid, byte_ready;
  logic [7:0]    byte_data;
  logic          fifo_write, fifo_full, fifo_read, fifo_empty;
  logic [7:0]    fifo_data_in, fifo_data_out;
  logic          tx_enable, tx_start, tx_done;
  logic [7:0]    tx_data;
  logic [LW-1:0] level;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_start = 0;
  int cnt_read  = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_tx[$];

  logic       force_full, tx_auto;
  logic [7:0] fq[$];
  int         fcnt;
  int         tx_cnt;

  always #5 clk = ~clk;

  uart_fifo_sched #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fifo_write(fifo_write), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
    .fifo_read(fifo_read), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .tx_enable(tx_enable), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .level(level), .err(err)
  );

  // Behavioural FIFO: read data appears the cycle after fifo_read.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
      fcnt          <= 0;
      fifo_data_out <= 8'h00;
    end else begin
      if (fifo_write) fq.push_back(fifo_data_in);
      if (fifo_read && fq.size() > 0) fifo_data_out <= fq.pop_front();
      fcnt <= fcnt + int'(fifo_write) - int'(fifo_read);
    end
  end
  assign fifo_full  = force_full | (fcnt >= DEPTH);
  assign fifo_empty = (fcnt == 0);

  // Transmitter: tx_done a fixed number of cycles after each tx_start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_done <= 1'b0;
      tx_cnt  <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_auto) begin
        if (tx_start) tx_cnt <= 5;
        else if (tx_cnt != 0) begin
          tx_cnt <= tx_cnt - 1;
          if (tx_cnt == 1) tx_done <= 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: FIFO write order and transmit order.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (fifo_write) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: fifo_data_in=%h with no byte expected", fifo_data_in);
        end else begin
          logic [7:0] e;
          e = exp_wr.pop_front();
          if (fifo_data_in !== e) begin
            n_bad++;
            $display("FAIL wr_data: got %h want %h", fifo_data_in, e);
          end
        end
      end
      if (tx_start) begin
        cnt_start++;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: tx_data=%h with no byte expected", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (tx_data !== e) begin
            n_bad++;
            $display("FAIL tx_data: got %h want %h", tx_data, e);
          end
        end
      end
      if (fifo_read) begin
        cnt_read++;
        n_cmp++;
        if (level == '0) begin
          n_bad++;
          $display("FAIL read_at_zero: fifo_read with level=%0d want level>0", level);
        end
      end
    end
  end

  task automatic push_pkt(input logic [23:0] d);
    exp_wr.push_back(d[7:0]);   exp_tx.push_back(d[7:0]);
    exp_wr.push_back(d[15:8]);  exp_tx.push_back(d[15:8]);
    exp_wr.push_back(d[23:16]); exp_tx.push_back(d[23:16]);
  endtask

  task automatic push_byte(input logic [7:0] d);
    exp_wr.push_back(d);
    exp_tx.push_back(d);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    pkt_valid = 1'b0; pkt_data = '0; byte_valid = 1'b0; byte_data = '0;
    tx_enable = 1'b0; tx_auto = 1'b0; force_full = 1'b0;
    exp_wr.delete(); exp_tx.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Offers a packet until accepted; called and returns at 1 time unit past a rising edge.
  task automatic send_pkt(input logic [23:0] d, output bit ok);
    ok = 1'b0;
    pkt_valid = 1'b1; pkt_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pkt_ready) begin push_pkt(d); ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    byte_valid = 1'b1; byte_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin push_byte(d); ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; force_full = 1'b0; tx_auto = 1'b0;
    pkt_valid = 1'b1; pkt_data = 24'hFFFFFF; byte_valid = 1'b1; byte_data = 8'hFF;
    tx_enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({pkt_ready, byte_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: pkt/byte_ready=%b want 00", {pkt_ready, byte_ready});
    end
    n_cmp++;
    if ({fifo_write, fifo_data_in} !== 9'h000) begin
      n_bad++; $display("FAIL reset_write: write=%b data=%h want 0 00", fifo_write, fifo_data_in);
    end
    n_cmp++;
    if ({fifo_read, tx_start, tx_data} !== 10'h000) begin
      n_bad++; $display("FAIL reset_read: read=%b start=%b data=%h want 0 0 00", fifo_read, tx_start, tx_data);
    end
    n_cmp++;
    if ({level, err} !== '0) begin
      n_bad++; $display("FAIL reset_level_err: level=%0d err=%b want 0 0", level, err);
    end
    do_reset;
  endtask

  task automatic test_single_packet;
    bit done;
    do_reset;
    pkt_valid = 1'b1; pkt_data = 24'hC3B2A1;
    @(negedge clk);
    n_cmp++;
    if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL pkt_first_ready: got %b want 1", pkt_ready); end
    if (pkt_ready) push_pkt(24'hC3B2A1);
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_write !== 1'b1) begin n_bad++; $display("FAIL pkt_write_n1: fifo_write=%b want 1", fifo_write); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (level !== LW'(k)) begin n_bad++; $display("FAIL pkt_level: got %0d want %0d", level, k); end
    end
    n_cmp++;
    if (fifo_write !== 1'b0) begin n_bad++; $display("FAIL pkt_write_end: fifo_write=%b want 0", fifo_write); end
    @(posedge clk); #1 tx_enable = 1'b1; tx_auto = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fifo_read !== 1'b1) begin n_bad++; $display("FAIL drain_read: fifo_read=%b want 1", fifo_read); end
    @(negedge clk);
    n_cmp++;
    if (tx_start !== 1'b0) begin n_bad++; $display("FAIL drain_start_early: tx_start=%b want 0", tx_start); end
    @(negedge clk);
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA1) begin
      n_bad++; $display("FAIL drain_start: tx_start=%b tx_data=%h want 1 a1", tx_start, tx_data);
    end
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (level == '0 && exp_tx.size() == 0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL pkt_drain_timeout: level=%0d left=%0d want 0 0", level, exp_tx.size()); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL pkt_err: got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    int  ng, pn, bn;
    int  g_cyc[4];
    bit  g_pkt[4];
    logic [7:0] pb;
    do_reset;
    ng = 0; pn = 0; bn = 0;
    pkt_valid = 1'b1; byte_valid = 1'b1;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      pb = 8'h10 + 8'(pn * 16);
      pkt_data  = {pb + 8'd2, pb + 8'd1, pb};
      byte_data = 8'hA0 + 8'(bn);
      @(negedge clk);
      n_cmp++;
      if (pkt_ready && byte_ready) begin n_bad++; $display("FAIL rr_double_grant: both ready at cycle %0d want one", c); end
      if (pkt_ready) begin
        push_pkt(pkt_data); g_pkt[ng] = 1'b1; g_cyc[ng] = c; ng++; pn++;
      end else if (byte_ready) begin
        push_byte(byte_data); g_pkt[ng] = 1'b0; g_cyc[ng] = c; ng++; bn++;
      end
      @(posedge clk); #1;
    end
    pkt_valid = 1'b0; byte_valid = 1'b0;
    n_cmp++;
    if (ng != 4) begin
      n_bad++; $display("FAIL rr_grants: got %0d grants want 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (g_pkt[i] != (i % 2 == 0)) begin
          n_bad++; $display("FAIL rr_order: grant %0d pkt=%b want %b", i, g_pkt[i], (i % 2 == 0));
        end
      end
      n_cmp++;
      if (g_cyc[1] - g_cyc[0] != 4 || g_cyc[2] - g_cyc[1] != 2 || g_cyc[3] - g_cyc[2] != 4) begin
        n_bad++; $display("FAIL rr_spacing: gaps %0d %0d %0d want 4 2 4",
                          g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1], g_cyc[3] - g_cyc[2]);
      end
    end
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (level !== LW'(8) || err !== 1'b0 || exp_wr.size() != 0) begin
      n_bad++; $display("FAIL rr_final: level=%0d err=%b pending=%0d want 8 0 0", level, err, exp_wr.size());
    end
  endtask

  task automatic test_fill;
    bit ok, all_ok;
    int np, nb;
    do_reset;
    cnt_read = 0;
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_pkt(24'h302010 + 24'(k) * 24'h040404, ok);
      all_ok &= ok;
    end
    send_byte(8'hD0, ok); all_ok &= ok;
    send_byte(8'hD1, ok); all_ok &= ok;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (!all_ok || level !== LW'(14)) begin
      n_bad++; $display("FAIL fill_setup: accepted=%b level=%0d want 1 14", all_ok, level);
    end
    np = 0; nb = 0;
    pkt_valid = 1'b1; pkt_data = 24'h777777; byte_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      byte_data = 8'hE0 + 8'(c);
      @(negedge clk);
      if (pkt_ready) np++;
      if (byte_ready) begin nb++; push_byte(byte_data); end
      @(posedge clk); #1;
    end
    pkt_valid = 1'b0; byte_valid = 1'b0;
    n_cmp++;
    if (np != 0) begin n_bad++; $display("FAIL fill_pkt_ready: got %0d grants want 0", np); end
    n_cmp++;
    if (nb != 2) begin n_bad++; $display("FAIL fill_byte_ready: got %0d grants want 2", nb); end
    n_cmp++;
    if (level !== LW'(16)) begin n_bad++; $display("FAIL fill_level: got %0d want 16", level); end
    n_cmp++;
    if (err !== 1'b0 || cnt_read != 0) begin
      n_bad++; $display("FAIL fill_quiet: err=%b reads=%0d want 0 0", err, cnt_read);
    end
  endtask

  task automatic test_drain;
    bit ok, all_ok, done;
    do_reset;
    all_ok = 1'b1;
    send_byte(8'h11, ok); all_ok &= ok;
    send_byte(8'h22, ok); all_ok &= ok;
    send_byte(8'h33, ok); all_ok &= ok;
    send_byte(8'h44, ok); all_ok &= ok;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (!all_ok || level !== LW'(4)) begin
      n_bad++; $display("FAIL drain_setup: accepted=%b level=%0d want 1 4", all_ok, level);
    end
    cnt_start = 0; cnt_read = 0;
    tx_auto = 1'b1; tx_enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (level == '0 && exp_tx.size() == 0) done = 1'b1;
    end
    repeat (12) @(posedge clk); #1;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL drain_timeout: level=%0d left=%0d want 0 0", level, exp_tx.size()); end
    n_cmp++;
    if (cnt_start != 4) begin n_bad++; $display("FAIL drain_starts: got %0d want 4", cnt_start); end
    n_cmp++;
    if (cnt_read != 4) begin n_bad++; $display("FAIL drain_reads: got %0d want 4", cnt_read); end
    n_cmp++;
    if (level !== '0 || err !== 1'b0) begin
      n_bad++; $display("FAIL drain_final: level=%0d err=%b want 0 0", level, err);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    pkt_valid = 1'b1; pkt_data = 24'h665544;
    @(negedge clk);
    n_cmp++;
    if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept: pkt_ready=%b want 1", pkt_ready); end
    if (pkt_ready) push_pkt(24'h665544);
    @(posedge clk); #1 pkt_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_wr.delete(); exp_tx.delete();
    #2;
    n_cmp++;
    if ({fifo_write, fifo_data_in, pkt_ready, byte_ready} !== 11'h000) begin
      n_bad++; $display("FAIL mid_reset_write: write=%b data=%h want 0 00", fifo_write, fifo_data_in);
    end
    n_cmp++;
    if (level !== '0) begin n_bad++; $display("FAIL mid_reset_level: got %0d want 0", level); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send_pkt(24'h998877, ok);
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (!ok || level !== LW'(3) || exp_wr.size() != 0) begin
      n_bad++; $display("FAIL mid_rewrite: accepted=%b level=%0d pending=%0d want 1 3 0", ok, level, exp_wr.size());
    end
  endtask

  task automatic test_err;
    bit ok;
    do_reset;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_initial: got %b want 0", err); end
    force_full = 1'b1;
    send_byte(8'h7E, ok);
    @(posedge clk); #1 force_full = 1'b0;
    n_cmp++;
    if (!ok || err !== 1'b1) begin n_bad++; $display("FAIL err_set: accepted=%b err=%b want 1 1", ok, err); end
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    reset = 1'b0;
    #2;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
    do_reset;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_packet;
    test_round_robin;
    test_fill;
    test_drain;
    test_reset_mid;
    test_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_sched.md
# uart_fifo_sched

Scheduler that owns both ports of the 8-bit UART FIFO. On the write side it arbitrates between the PS/2 mouse packet source (3-byte packets, written atomically) and a single-byte command/status source. On the read side it drains the FIFO into the UART transmitter one byte at a time under a start/done handshake. It tracks FIFO occupancy internally, so packets are admitted only when all three bytes fit.

## Interface
- DEPTH, 16: FIFO capacity in bytes; must be ≥ 3.
- LW, 5: width of the level counter; must satisfy 2^LW > DEPTH.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- pkt_valid  in  1  mouse packet offered
- pkt_data  in  24  packet; byte0 = [7:0] written first, byte2 = [23:16] last
- pkt_ready  out  1  packet accepted this cycle (valid & ready)
- byte_valid  in  1  single byte offered
- byte_data  in  8  byte payload
- byte_ready  out  1  byte accepted this cycle
- fifo_write  out  1  FIFO write strobe
- fifo_data_in  out  8  FIFO write data
- fifo_full  in  1  FIFO full flag, used only for error checking
- fifo_read  out  1  FIFO read strobe
- fifo_data_out  in  8  FIFO read data, valid the cycle after fifo_read
- fifo_empty  in  1  FIFO empty flag, used only for error checking
- tx_enable  in  1  0 pauses draining; an in-flight byte completes
- tx_start  out  1  one-cycle pulse, begin sending tx_data
- tx_data  out  8  byte to transmit, held from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, transmitter finished
- level  out  LW  scheduler's occupancy count
- err  out  1  sticky flag: write while fifo_full, or read while fifo_empty

## Operation
- Reset values: every output is 0. Write FSM = W_IDLE, read FSM = R_IDLE, level = 0, last_grant = byte source (so the packet source wins the first tie).
- Write FSM states: W_IDLE, W_B0, W_B1, W_B2, W_BYTE.
- Eligibility in W_IDLE:
  - packet source: pkt_valid & (level ≤ DEPTH−3)
  - byte source: byte_valid & (level ≤ DEPTH−1)
- Grant in W_IDLE:
  - one eligible source: grant it.
  - both eligible: round-robin, grant the source not in last_grant.
  - Level is the value registered at the start of the cycle.
- Packet grant:
  - pkt_ready=1 (combinational, W_IDLE only); pkt_data is latched.
  - Then W_B0, W_B1, W_B2 each drive fifo_write=1 with byte0, byte1, byte2 in that order, then return to W_IDLE.
  - The byte source is never interleaved inside a packet.
- Byte grant: byte_ready=1, byte_data latched, W_BYTE drives fifo_write=1, then W_IDLE.
- Read FSM states: R_IDLE, R_LOAD, R_START, R_WAIT.
  - R_IDLE: if level > 0 & tx_enable, drive fifo_read=1 → R_LOAD.
  - R_LOAD: latch fifo_data_out into tx_data → R_START.
  - R_START: tx_start=1 → R_WAIT.
  - R_WAIT: on tx_done → R_IDLE.
  - A tx_done in any other state is ignored.
- Level arithmetic:
  - +1 on fifo_write, −1 on fifo_read, unchanged when both occur in the same cycle.
  - Never wraps: admission rules forbid overflow, and reads require level > 0.
- err is set on fifo_write & fifo_full, or on fifo_read & fifo_empty. It is cleared only by reset. Write and read behaviour is unaffected by err.
- Reset mid-operation: both FSMs return to idle and a partially written packet is abandoned. The FIFO shares the same reset, so level = 0 stays consistent.

## Timing
- Packet accepted in cycle N → fifo_write in N+1, N+2, N+3. Next grant is possible in N+4.
- Byte accepted in cycle N → fifo_write in N+1. Next grant is possible in N+2.
- Sustained throughput: 3 bytes per 4 cycles for packets, 1 byte per 2 cycles for single bytes.
- Drain: fifo_read in cycle N, tx_data valid from N+2, tx_start high in N+2. tx_done in cycle M → next fifo_read no earlier than M+1.
- pkt_ready and byte_ready are combinational from valid, level and state. They never depend on the ready outputs.
- Simultaneous write and read on the same edge is legal. Admission uses the pre-edge level, so it is conservative by at most one byte.

## Test plan
- Reset, then pkt_valid with pkt_data=24'hC3B2A1 → pkt_ready in cycle 1; fifo_write on the next 3 cycles with A1, B2, C3; level goes 0→3; tx_start follows with tx_data=A1.
- Both sources valid every cycle, tx_enable=0 → grants alternate P, B, P, B; packet bytes are contiguous in FIFO order; err=0.
- tx_enable=0, fill to level=14 (DEPTH=16) → pkt_ready stays 0 while byte_ready fires twice up to level=16; then both ready outputs stay 0.
- tx_enable=1, tx_done returned 5 cycles after each tx_start, 4 bytes queued → exactly 4 tx_start pulses in FIFO order, one fifo_read per byte, level ends at 0, fifo_read never asserted at level 0.
- Assert reset during W_B1 → all outputs 0 asynchronously, level=0; after release a new packet is written in full.
- Force fifo_full=1 during a W_BYTE write → err=1, remains 1 until reset.
